serial_adder_ctrl: RTL

Bit-serial addition controller that sequences a single `full_adder` instance to add two WIDTH-bit operands, one bit per clock, LSB first. It captures operands through a valid/ready input handshake and shifts them through the adder with a registered carry. It then presents the WIDTH-bit sum and carry-out through a valid/ready output handshake. It is the area-minimal alternative to a ripple-carry array, used wherever an add can take WIDTH cycles.

---
 rtl/serial_adder_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder stepped LSB-first for WIDTH cycles with a registered carry,
// operands taken on a valid/ready input handshake and the result held for a valid/ready output.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one adder bit per cycle, LSB first
// DONE  | result held until out_ready
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, sum_q;
  logic [WIDTH-1:0] res_next;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // the new bit enters at the MSB so after WIDTH steps the LSB sits at bit 0
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_next = fa_s;
    end else begin : g_wn
      assign res_next = {fa_s, res_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_RUN);
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          res_sh_q <= res_next;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          carry_q  <= fa_co;
          if (cnt_q == LAST) begin
            sum_q  <= res_next;
            cout_q <= fa_co;
          end else begin
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
